// File: rtl/grad_magnitude.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : grad_magnitude                                               |
// | Description : 2-stage elastic gradient-magnitude stage, max + min/2 (or L1  |
// |               when GRAD_MAG_L1_EN is defined), saturated, gx/gy passthrough.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module grad_magnitude #(
  parameter int width_p      = 8,
  parameter int width_grad_p = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    valid_i,
  input  logic [width_grad_p-1:0] gx_i,
  input  logic [width_grad_p-1:0] gy_i,
  output logic                    ready_o,
  output logic                    valid_o,
  output logic [width_p-1:0]      mag_o,
  output logic [width_grad_p-1:0] gx_o,
  output logic [width_grad_p-1:0] gy_o,
  input  logic                    ready_i
);

  localparam int c_sum_w = width_grad_p + 1;

  logic                    w_ready_s1;
  logic                    w_ready_s2;
  logic [width_grad_p-1:0] w_ax;
  logic [width_grad_p-1:0] w_ay;
  logic [c_sum_w-1:0]      w_sum;
  logic [width_p-1:0]      w_mag;

  logic                    r_valid_s1;
  logic [width_grad_p-1:0] r_ax;
  logic [width_grad_p-1:0] r_ay;
  logic [width_grad_p-1:0] r_gx_s1;
  logic [width_grad_p-1:0] r_gy_s1;

  logic                    r_valid_s2;
  logic [width_p-1:0]      r_mag;
  logic [width_grad_p-1:0] r_gx_s2;
  logic [width_grad_p-1:0] r_gy_s2;

  assign w_ready_s2 = ~r_valid_s2 | ready_i;
  assign w_ready_s1 = ~r_valid_s1 | w_ready_s2;
  assign ready_o    = w_ready_s1;

  // Magnitude of the most negative code is 2^(w-1), which still fits unsigned.
  assign w_ax = gx_i[width_grad_p-1] ? (~gx_i + width_grad_p'(1)) : gx_i;
  assign w_ay = gy_i[width_grad_p-1] ? (~gy_i + width_grad_p'(1)) : gy_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_valid_s1 <= 1'b0;
      r_ax       <= '0;
      r_ay       <= '0;
      r_gx_s1    <= '0;
      r_gy_s1    <= '0;
    end else if (w_ready_s1) begin
      r_valid_s1 <= valid_i;
      if (valid_i) begin
        r_ax    <= w_ax;
        r_ay    <= w_ay;
        r_gx_s1 <= gx_i;
        r_gy_s1 <= gy_i;
      end
    end
  end

`ifdef GRAD_MAG_L1_EN
  assign w_sum = {1'b0, r_ax} + {1'b0, r_ay};
`else
  logic [width_grad_p-1:0] w_hi;
  logic [width_grad_p-1:0] w_lo;

  assign w_hi  = (r_ay > r_ax) ? r_ay : r_ax;
  assign w_lo  = (r_ay > r_ax) ? r_ax : r_ay;
  assign w_sum = {1'b0, w_hi} + {2'b00, w_lo[width_grad_p-1:1]};
`endif

  generate
    if (width_p > c_sum_w) begin : g_zext
      assign w_mag = {{(width_p - c_sum_w){1'b0}}, w_sum};
    end else if (width_p == c_sum_w) begin : g_equal
      assign w_mag = w_sum;
    end else begin : g_sat
      assign w_mag = (|w_sum[c_sum_w-1:width_p]) ? {width_p{1'b1}} : w_sum[width_p-1:0];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_valid_s2 <= 1'b0;
      r_mag      <= '0;
      r_gx_s2    <= '0;
      r_gy_s2    <= '0;
    end else if (w_ready_s2) begin
      r_valid_s2 <= r_valid_s1;
      if (r_valid_s1) begin
        r_mag   <= w_mag;
        r_gx_s2 <= r_gx_s1;
        r_gy_s2 <= r_gy_s1;
      end
    end
  end

  assign valid_o = r_valid_s2;
  assign mag_o   = r_mag;
  assign gx_o    = r_gx_s2;
  assign gy_o    = r_gy_s2;

endmodule
`default_nettype wire

// File: tb/tb_grad_magnitude.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_grad_magnitude                                            |
// | Description : Scoreboard bench for grad_magnitude (honours GRAD_MAG_L1_EN). |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_grad_magnitude;

  localparam int c_w  = 8;
  localparam int c_wg = 8;

  typedef struct packed {
    logic [c_w-1:0]  mag;
    logic [c_wg-1:0] gx;
    logic [c_wg-1:0] gy;
  } item_t;

  logic            clk_i = 1'b0;
  logic            reset_i = 1'b1;
  logic            valid_i = 1'b0;
  logic [c_wg-1:0] gx_i = '0;
  logic [c_wg-1:0] gy_i = '0;
  logic            ready_o;
  logic            valid_o;
  logic [c_w-1:0]  mag_o;
  logic [c_wg-1:0] gx_o;
  logic [c_wg-1:0] gy_o;
  logic            ready_i = 1'b1;

  int    checks = 0;
  int    errors = 0;
  int    popped = 0;
  item_t sb[$];

  grad_magnitude #(.width_p(c_w), .width_grad_p(c_wg)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .valid_i (valid_i),
    .gx_i    (gx_i),
    .gy_i    (gy_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .mag_o   (mag_o),
    .gx_o    (gx_o),
    .gy_o    (gy_o),
    .ready_i (ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Reference: Euclidean-norm approximation from the arithmetic rules, in plain ints.
  function automatic logic [c_w-1:0] model_mag(input logic [c_wg-1:0] gx, input logic [c_wg-1:0] gy);
    int sx, sy, ax, ay, hi, lo, s;
    sx = int'($signed(gx));
    sy = int'($signed(gy));
    ax = (sx < 0) ? -sx : sx;
    ay = (sy < 0) ? -sy : sy;
    hi = (ax > ay) ? ax : ay;
    lo = (ax > ay) ? ay : ax;
`ifdef GRAD_MAG_L1_EN
    s = ax + ay;
`else
    s = hi + lo / 2;
`endif
    if (s > (1 << c_w) - 1) s = (1 << c_w) - 1;
    return c_w'(s);
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // One cycle of stimulus; pushes the expected result if the beat is accepted.
  task automatic cyc(input logic v, input logic [c_wg-1:0] gx, input logic [c_wg-1:0] gy,
                     input logic rdy, output logic acc);
    @(negedge clk_i);
    valid_i = v;
    gx_i    = gx;
    gy_i    = gy;
    ready_i = rdy;
    #1;
    acc = valid_i & ready_o;
    if (acc) sb.push_back('{mag: model_mag(gx, gy), gx: gx, gy: gy});
  endtask

  task automatic offer(input logic [c_wg-1:0] gx, input logic [c_wg-1:0] gy, input logic rdy);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      cyc(1'b1, gx, gy, rdy, acc);
      n++;
    end
    if (!acc) chk("offer_timeout", 0, 1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      reset_i = 1'b1;
      valid_i = 1'b1;
      gx_i    = 8'h55;
      gy_i    = 8'h2A;
      sb.delete();
    end
    @(negedge clk_i);
    #1;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_mag_o", mag_o, 0);
    chk("rst_gx_o", gx_o, 0);
    chk("rst_gy_o", gy_o, 0);
    reset_i = 1'b0;
    valid_i = 1'b0;
    #1;
    chk("rst_ready_o", ready_o, 1);
  endtask

  // Monitor: pops on each output transfer and checks hold-stability under stall.
  logic  prev_stall = 1'b0;
  item_t held;
  always @(negedge clk_i) begin
    #2;
    if (reset_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", valid_o, 1);
        chk("stall_data_hold", {mag_o, gx_o, gy_o}, held);
      end
      if (valid_o && ready_i) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          item_t e;
          e = sb.pop_front();
          popped++;
          chk("out_mag", mag_o, e.mag);
          chk("out_gx", gx_o, e.gx);
          chk("out_gy", gy_o, e.gy);
        end
      end
      prev_stall = valid_o & ~ready_i;
      held       = '{mag: mag_o, gx: gx_o, gy: gy_o};
    end
  end

  logic acc;
  int   n_acc, n_cyc, p0;

  initial begin
    do_reset(3);

    // Single beat 3,4: latency exactly 2, single-cycle valid.
    p0 = popped;
    cyc(1'b1, 8'd3, 8'd4, 1'b1, acc);
    chk("single_accept", acc, 1);
    cyc(1'b0, 8'd0, 8'd0, 1'b1, acc);
    chk("lat_cycle1_valid", valid_o, 0);
    cyc(1'b0, 8'd0, 8'd0, 1'b1, acc);
    chk("lat_cycle2_valid", valid_o, 1);
`ifdef GRAD_MAG_L1_EN
    chk("mag_3_4", mag_o, 7);
`else
    chk("mag_3_4", mag_o, 5);
`endif
    cyc(1'b0, 8'd0, 8'd0, 1'b1, acc);
    chk("lat_cycle3_valid", valid_o, 0);
    chk("single_popped", popped - p0, 1);

    // Corner values: most negative, mixed sign, zero.
    offer(8'h80, 8'h80, 1'b1);
    offer(8'd127, 8'hFF, 1'b1);
    offer(8'd0, 8'd0, 1'b1);
    offer(8'h80, 8'd127, 1'b1);
    repeat (3) cyc(1'b0, 8'd0, 8'd0, 1'b1, acc);

    // Backpressure: two beats fill the pipe, then ready_o drops.
    offer(8'd1, 8'd0, 1'b0);
    offer(8'd2, 8'd0, 1'b0);
    cyc(1'b1, 8'd3, 8'd0, 1'b0, acc);
    chk("bp_full_ready_o", ready_o, 0);
    chk("bp_valid_o", valid_o, 1);
    chk("bp_mag_hold", mag_o, 1);
    repeat (3) cyc(1'b1, 8'd3, 8'd0, 1'b0, acc);
    p0 = popped;
    offer(8'd3, 8'd0, 1'b1);
    offer(8'd4, 8'd0, 1'b1);
    repeat (4) cyc(1'b0, 8'd0, 8'd0, 1'b1, acc);
    chk("bp_drained", popped - p0, 4);

    // Reset with two items stuck behind backpressure.
    offer(8'd9, 8'd9, 1'b0);
    offer(8'd10, 8'd10, 1'b0);
    do_reset(1);
    p0 = popped;
    cyc(1'b0, 8'd0, 8'd0, 1'b1, acc);
    chk("post_rst_no_stale", valid_o, 0);
    offer(8'hF6, 8'd20, 1'b1);
    repeat (3) cyc(1'b0, 8'd0, 8'd0, 1'b1, acc);
    chk("post_rst_one_item", popped - p0, 1);

    // Randomised traffic.
    n_acc = 0;
    n_cyc = 0;
    while (n_acc < 1000 && n_cyc < 20000) begin
      logic [c_wg-1:0] rx, ry;
      rx = ($urandom_range(0, 7) == 0) ? 8'h80 : c_wg'($urandom);
      ry = ($urandom_range(0, 7) == 0) ? 8'h7F : c_wg'($urandom);
      cyc(($urandom_range(0, 3) != 0), rx, ry, ($urandom_range(0, 3) != 0), acc);
      if (acc) n_acc++;
      n_cyc++;
    end
    chk("random_beats_accepted", n_acc, 1000);
    n_cyc = 0;
    while (sb.size() != 0 && n_cyc < 100) begin
      cyc(1'b0, 8'd0, 8'd0, 1'b1, acc);
      n_cyc++;
    end
    cyc(1'b0, 8'd0, 8'd0, 1'b1, acc);
    chk("scoreboard_empty", sb.size(), 0);
    chk("final_valid_o", valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
